// File: rtl/event_encoder.sv
// Multi-hot event capture with a pending register and a registered
// lowest-index-first encoder behind a valid/ready output handshake.
module event_encoder #(
  parameter int IN_WIDTH  = 16,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [IN_WIDTH-1:0]  event_in,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_WIDTH-1:0]  pending,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  logic [IN_WIDTH-1:0]  pending_reg;
  logic [IN_WIDTH-1:0]  pending_next;
  logic [IDX_WIDTH-1:0] idx_reg;
  logic [IDX_WIDTH-1:0] idx_next;
  logic                 valid_reg;
  logic                 valid_next;
  logic                 overflow_reg;
  logic                 overflow_next;

  logic                 handshake;
  logic                 load;
  logic [IN_WIDTH-1:0]  served;
  logic [IN_WIDTH-1:0]  remaining;
  logic [IN_WIDTH-1:0]  captured;
  logic [IDX_WIDTH-1:0] lowest_idx;

  assign handshake = valid_reg & out_ready;
  assign load      = ~valid_reg | handshake;

  // One-hot decode of the presented index, only during a handshake.
  for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_served
    assign served[gi] = handshake && (idx_reg == IDX_WIDTH'(gi));
  end

  assign remaining = pending_reg & ~served;
  assign captured  = enable ? event_in : '0;

  // Lowest set bit wins; scanning downward leaves the smallest index last.
  always_comb begin
    lowest_idx = '0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (remaining[i]) lowest_idx = IDX_WIDTH'(i);
    end
  end

  always_comb begin
    pending_next  = remaining | captured;
    valid_next    = valid_reg;
    idx_next      = idx_reg;
    overflow_next = overflow_reg;
    // Only the already-pending snapshot is encoded; fresh events wait a cycle.
    if (load) begin
      valid_next = |remaining;
      idx_next   = lowest_idx;
    end
    // A lost event outranks a clear request in the same cycle.
    if (|(captured & remaining)) begin
      overflow_next = 1'b1;
    end else if (clear_overflow) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg  <= '0;
      valid_reg    <= 1'b0;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      valid_reg    <= valid_next;
      idx_reg      <= idx_next;
      overflow_reg <= overflow_next;
    end
  end

  assign pending   = pending_reg;
  assign out_valid = valid_reg;
  assign out_idx   = idx_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_event_encoder.sv
// Directed-vector bench for event_encoder with hand-computed expectations.
module tb_event_encoder;

  localparam int IN_WIDTH  = 16;
  localparam int IDX_WIDTH = 4;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [IN_WIDTH-1:0]  event_in;
  logic [IDX_WIDTH-1:0] out_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic [IN_WIDTH-1:0]  pending;
  logic                 overflow;
  logic                 clear_overflow;

  int check_count;
  int error_count;

  event_encoder #(
    .IN_WIDTH  (IN_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .event_in       (event_in),
    .out_idx        (out_idx),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pending        (pending),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle; one line per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pending=0x%04h valid=%0b idx=%0d ovf=%0b", $time, pending, out_valid, out_idx, overflow);
  endtask

  task automatic expect_state(input string tag, input logic [15:0] p, input logic v,
                              input logic [3:0] idx, input logic ovf);
    check({tag, ".pending"},   32'(pending),   32'(p));
    check({tag, ".valid"},     32'(out_valid), 32'(v));
    check({tag, ".idx"},       32'(out_idx),   32'(idx));
    check({tag, ".overflow"},  32'(overflow),  32'(ovf));
  endtask

  initial begin
    check_count    = 0;
    error_count    = 0;
    rst            = 1'b1;
    enable         = 1'b1;
    event_in       = 16'h0000;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;

    #2;
    expect_state("reset", 16'h0000, 1'b0, 4'd0, 1'b0);
    event_in = 16'hFFFF;
    tick();
    expect_state("reset_held", 16'h0000, 1'b0, 4'd0, 1'b0);
    rst      = 1'b0;
    event_in = 16'h0000;

    // Single event, one-cycle latency to pending, two to out_valid.
    out_ready = 1'b1;
    event_in  = 16'h0100;
    tick();
    event_in = 16'h0000;
    expect_state("single.e1", 16'h0100, 1'b0, 4'd0, 1'b0);
    tick();
    expect_state("single.e2", 16'h0100, 1'b1, 4'd8, 1'b0);
    tick();
    expect_state("single.e3", 16'h0000, 1'b0, 4'd0, 1'b0);

    // Multi-hot drains in ascending order, back to back.
    event_in = 16'h8005;
    tick();
    event_in = 16'h0000;
    expect_state("multi.e1", 16'h8005, 1'b0, 4'd0, 1'b0);
    tick();
    expect_state("multi.i0", 16'h8005, 1'b1, 4'd0, 1'b0);
    tick();
    expect_state("multi.i2", 16'h8004, 1'b1, 4'd2, 1'b0);
    tick();
    expect_state("multi.i15", 16'h8000, 1'b1, 4'd15, 1'b0);
    tick();
    expect_state("multi.done", 16'h0000, 1'b0, 4'd0, 1'b0);

    // Backpressure: a lower index arriving later must not preempt.
    out_ready = 1'b0;
    event_in  = 16'h0004;
    tick();
    event_in = 16'h0000;
    tick();
    expect_state("bp.present", 16'h0004, 1'b1, 4'd2, 1'b0);
    event_in = 16'h0001;
    tick();
    event_in = 16'h0000;
    expect_state("bp.hold1", 16'h0005, 1'b1, 4'd2, 1'b0);
    tick();
    expect_state("bp.hold2", 16'h0005, 1'b1, 4'd2, 1'b0);
    out_ready = 1'b1;
    tick();
    expect_state("bp.next0", 16'h0001, 1'b1, 4'd0, 1'b0);
    tick();
    expect_state("bp.done", 16'h0000, 1'b0, 4'd0, 1'b0);

    // Overflow set, clear, and set-beats-clear.
    out_ready = 1'b0;
    event_in  = 16'h0010;
    tick();
    expect_state("ovf.first", 16'h0010, 1'b0, 4'd0, 1'b0);
    tick();
    event_in = 16'h0000;
    expect_state("ovf.second", 16'h0010, 1'b1, 4'd4, 1'b1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf.cleared", 32'(overflow), 32'd0);
    clear_overflow = 1'b1;
    event_in       = 16'h0010;
    tick();
    clear_overflow = 1'b0;
    event_in       = 16'h0000;
    check("ovf.set_wins", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf.cleared2", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    tick();
    expect_state("ovf.drain", 16'h0000, 1'b0, 4'd0, 1'b0);

    // Serve plus re-request on the same line.
    out_ready = 1'b0;
    event_in  = 16'h0008;
    tick();
    event_in = 16'h0000;
    tick();
    expect_state("rereq.present", 16'h0008, 1'b1, 4'd3, 1'b0);
    out_ready = 1'b1;
    event_in  = 16'h0008;
    tick();
    event_in = 16'h0000;
    expect_state("rereq.served", 16'h0008, 1'b0, 4'd0, 1'b0);
    tick();
    expect_state("rereq.reissue", 16'h0008, 1'b1, 4'd3, 1'b0);
    tick();
    expect_state("rereq.done", 16'h0000, 1'b0, 4'd0, 1'b0);

    // enable=0 ignores events and overflow but keeps draining.
    out_ready = 1'b0;
    event_in  = 16'h0006;
    tick();
    event_in = 16'h0000;
    tick();
    expect_state("dis.present", 16'h0006, 1'b1, 4'd1, 1'b0);
    enable    = 1'b0;
    out_ready = 1'b1;
    event_in  = 16'h0005;
    tick();
    expect_state("dis.drain1", 16'h0004, 1'b1, 4'd2, 1'b0);
    tick();
    event_in = 16'h0000;
    expect_state("dis.drain2", 16'h0000, 1'b0, 4'd0, 1'b0);
    enable = 1'b1;

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    event_in  = 16'h00F0;
    tick();
    tick();
    event_in = 16'h0000;
    expect_state("mid.before", 16'h00F0, 1'b1, 4'd4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    expect_state("mid.async", 16'h0000, 1'b0, 4'd0, 1'b0);
    #1;
    rst      = 1'b0;
    event_in = 16'h0002;
    tick();
    event_in = 16'h0000;
    expect_state("mid.first_capture", 16'h0002, 1'b0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
